// File: rtl/writeback_pkg.sv
// Shared constants and the MEM/WB register layout for the writeback stage.
// Decode's control unit uses the same source-op and load funct3 encodings.
package writeback_pkg;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;
    localparam logic [1:0] SRC_IMM  = 2'b11;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  src_op;
        logic [2:0]  mask;
        logic [1:0]  addr_lo;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [31:0] immediate;
        logic [31:0] dmem_rdata;
    } wb_reg_t;

endpackage

// File: rtl/writeback_load_align.sv
// Byte/half/word extraction and sign/zero extension of word-aligned load data.
// Misalignment is reported purely from offset and mask; the caller qualifies it.
module load_align
    import writeback_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  mask,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte lane.
    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane by load type; undefined funct3 yields zero.
    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        case (mask)
            LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LBU: data = {24'h0, byte_sel};
            LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            LHU: begin
                data       = {16'h0, half_sel};
                misaligned = offset[0];
            end
            LW: begin
                data       = rdata;
                misaligned = (offset != 2'd0);
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// RV32I writeback stage: MEM/WB register, result select, rd write port to
// decode, retired-instruction counter and misaligned-load flag.
module writeback
    import writeback_pkg::*;
#(
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic [4:0]               i_rd,
    input  logic                     i_reg_write,
    input  logic [1:0]               i_reg_write_source_op,
    input  logic [2:0]               i_dmem_mask,
    input  logic [31:0]              i_alu_result,
    input  logic [31:0]              i_pc_plus4,
    input  logic [31:0]              i_immediate,
    input  logic [31:0]              i_dmem_rdata,
    output logic                     o_rd_wen,
    output logic [4:0]               o_rd_waddr,
    output logic [31:0]              o_rd_wdata,
    output logic                     o_retire,
    output logic                     o_misaligned,
    output logic [INSTRET_WIDTH-1:0] o_instret
);

    wb_reg_t                  wb_q;
    logic [31:0]              load_data;
    logic                     align_err;
    logic                     load_misaligned;
    logic [31:0]              result;
    logic [INSTRET_WIDTH-1:0] instret_q;

    // MEM/WB register: a bubble is an all-zero bundle so waddr/wdata read 0 too.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wb_q <= '0;
        end else if (i_flush) begin
            wb_q <= '0;
        end else if (!i_stall) begin
            wb_q <= '{valid:      i_valid,
                      rd:         i_rd,
                      reg_write:  i_reg_write,
                      src_op:     i_reg_write_source_op,
                      mask:       i_dmem_mask,
                      addr_lo:    i_alu_result[1:0],
                      alu_result: i_alu_result,
                      pc_plus4:   i_pc_plus4,
                      immediate:  i_immediate,
                      dmem_rdata: i_dmem_rdata};
        end
    end

    load_align u_load_align (
        .rdata      (wb_q.dmem_rdata),
        .offset     (wb_q.addr_lo),
        .mask       (wb_q.mask),
        .data       (load_data),
        .misaligned (align_err)
    );

    // Only a real load instruction can be misaligned.
    assign load_misaligned = wb_q.valid & (wb_q.src_op == SRC_LOAD) & align_err;

    // Result select by source op.
    always_comb begin
        result = wb_q.alu_result;
        case (wb_q.src_op)
            SRC_ALU:  result = wb_q.alu_result;
            SRC_LOAD: result = load_data;
            SRC_PC4:  result = wb_q.pc_plus4;
            SRC_IMM:  result = wb_q.immediate;
            default:  result = wb_q.alu_result;
        endcase
    end

    // Write stays asserted while stalled; rewriting the same value is harmless.
    assign o_rd_wen     = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0) & ~load_misaligned;
    assign o_rd_waddr   = wb_q.rd;
    assign o_rd_wdata   = result;
    assign o_retire     = wb_q.valid & ~i_stall;
    assign o_misaligned = load_misaligned;
    assign o_instret    = instret_q;

    // Retired-instruction counter, wraps naturally at its maximum.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            instret_q <= '0;
        end else if (o_retire) begin
            instret_q <= instret_q + INSTRET_WIDTH'(1);
        end
    end

endmodule
